// File: rtl/conv_row_mac.sv
// Serial 3x3 window MAC: accumulates 9 pixel*weight pairs in row-major order
// and presents the three per-row dot products in parallel with a done flag.
module conv_row_mac #(
    parameter int DATA_W   = 8,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ack,
    output logic [DATA_W-1:0] row_sum0,
    output logic [DATA_W-1:0] row_sum1,
    output logic [DATA_W-1:0] row_sum2,
    output logic              done
);

    // Two guard bits cover three full-scale products per row.
    localparam int ACC_W  = 2 * DATA_W + 2;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [1:0]         row_q, row_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]  sum0_q, sum0_d;
    logic [DATA_W-1:0]  sum1_q, sum1_d;
    logic [DATA_W-1:0]  sum2_q, sum2_d;

    logic [PROD_W-1:0]  product;
    logic [ACC_W-1:0]   acc_next;
    logic [DATA_W-1:0]  folded;
    logic               accept;

    assign in_ready = (state_q == ACCUM);
    assign done     = (state_q == HOLD);
    assign accept   = in_valid && in_ready;

    assign product  = {{DATA_W{1'b0}}, pixel_in} * {{DATA_W{1'b0}}, weight_in};
    assign acc_next = acc_q + ACC_W'(product);

    // Any bit above DATA_W set means the row sum exceeds the output range.
    always_comb begin
        if ((SATURATE != 0) && (|acc_next[ACC_W-1:DATA_W])) begin
            folded = {DATA_W{1'b1}};
        end else begin
            folded = acc_next[DATA_W-1:0];
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        acc_d   = acc_q;
        sum0_d  = sum0_q;
        sum1_d  = sum1_q;
        sum2_d  = sum2_q;

        if (!enable) begin
            // Synchronous clear wins over any accept or ack in the same cycle.
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
            acc_d   = '0;
            sum0_d  = '0;
            sum1_d  = '0;
            sum2_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ACCUM;
                ACCUM: begin
                    if (accept) begin
                        if (col_q == 2'd2) begin
                            acc_d = '0;
                            col_d = '0;
                            unique case (row_q)
                                2'd0:    sum0_d = folded;
                                2'd1:    sum1_d = folded;
                                default: sum2_d = folded;
                            endcase
                            if (row_q == 2'd2) begin
                                row_d   = '0;
                                state_d = HOLD;
                            end else begin
                                row_d = row_q + 2'd1;
                            end
                        end else begin
                            acc_d = acc_next;
                            col_d = col_q + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        state_d = ACCUM;
                        col_d   = '0;
                        row_d   = '0;
                        acc_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            sum0_q  <= '0;
            sum1_q  <= '0;
            sum2_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            sum0_q  <= sum0_d;
            sum1_q  <= sum1_d;
            sum2_q  <= sum2_d;
        end
    end

    assign row_sum0 = sum0_q;
    assign row_sum1 = sum1_q;
    assign row_sum2 = sum2_q;

endmodule

// File: tb/tb_conv_row_mac.sv
// Bench for conv_row_mac: modulo and saturating instances driven in parallel,
// expected row sums queued at stimulus time and compared when done rises.
module tb_conv_row_mac;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] pixel_in;
    logic [DW-1:0] weight_in;
    logic          in_valid;
    logic          out_ack;

    logic          in_ready, in_ready_s;
    logic [DW-1:0] rs0, rs1, rs2;
    logic [DW-1:0] ss0, ss1, ss2;
    logic          done, done_s;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DW-1:0] m0, m1, m2;
        logic [DW-1:0] s0, s1, s2;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    logic done_prev = 1'b0;

    conv_row_mac #(.DATA_W(DW), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pixel_in(pixel_in), .weight_in(weight_in),
        .in_valid(in_valid), .in_ready(in_ready), .out_ack(out_ack),
        .row_sum0(rs0), .row_sum1(rs1), .row_sum2(rs2), .done(done)
    );

    conv_row_mac #(.DATA_W(DW), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pixel_in(pixel_in), .weight_in(weight_in),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_ack(out_ack),
        .row_sum0(ss0), .row_sum1(ss1), .row_sum2(ss2), .done(done_s)
    );

    always #5 clk = ~clk;

    // Scoreboard: on each rising done, pop the oldest expected window.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_empty: done rose with no expected window queued");
            end else begin
                last_exp = sb_q.pop_front();
                checks++;
                if ({rs0, rs1, rs2} !== {last_exp.m0, last_exp.m1, last_exp.m2}) begin
                    failures++;
                    $display("FAIL sb_mod: got %0d,%0d,%0d expected %0d,%0d,%0d",
                             rs0, rs1, rs2, last_exp.m0, last_exp.m1, last_exp.m2);
                end
                checks++;
                if ({ss0, ss1, ss2, done_s} !== {last_exp.s0, last_exp.s1, last_exp.s2, 1'b1}) begin
                    failures++;
                    $display("FAIL sb_sat: got %0d,%0d,%0d done=%0b expected %0d,%0d,%0d done=1",
                             ss0, ss1, ss2, done_s, last_exp.s0, last_exp.s1, last_exp.s2);
                end
            end
        end
        done_prev <= done;
    end

    task automatic push_expected(input logic [DW-1:0] px[9], input logic [DW-1:0] wt[9]);
        exp_t e;
        int   sum[3];
        for (int r = 0; r < 3; r++) begin
            sum[r] = 0;
            for (int c = 0; c < 3; c++) sum[r] += int'(px[r*3+c]) * int'(wt[r*3+c]);
        end
        e.m0 = DW'(sum[0] % 256);
        e.m1 = DW'(sum[1] % 256);
        e.m2 = DW'(sum[2] % 256);
        e.s0 = (sum[0] > 255) ? 8'd255 : DW'(sum[0]);
        e.s1 = (sum[1] > 255) ? 8'd255 : DW'(sum[1]);
        e.s2 = (sum[2] > 255) ? 8'd255 : DW'(sum[2]);
        sb_q.push_back(e);
    endtask

    // Drives n pairs; returns at #1 after the edge that accepts the last one.
    task automatic send_pairs(input logic [DW-1:0] px[9], input logic [DW-1:0] wt[9],
                              input int n, input bit gaps);
        int k = 0;
        bit idle_slot = 1'b0;
        while (k < n) begin
            int budget = 0;
            if (gaps && idle_slot) begin
                in_valid = 1'b0;
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL gap_ready: in_ready=%0b expected 1 during gap", in_ready);
                end
                @(posedge clk); #1;
                idle_slot = 1'b0;
                continue;
            end
            in_valid  = 1'b1;
            pixel_in  = px[k];
            weight_in = wt[k];
            while (!in_ready && budget < 50) begin
                @(posedge clk); #1;
                budget++;
            end
            if (budget >= 50) begin
                failures++;
                $display("FAIL accept_timeout: in_ready=%0b expected 1 within 50 cycles", in_ready);
                in_valid = 1'b0;
                return;
            end
            if (k == 8) begin
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL early_done: done=%0b expected 0 before 9th accept", done);
                end
            end
            @(posedge clk); #1;
            k++;
            idle_slot = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
        checks++;
        if ({done, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL ack: done=%0b in_ready=%0b expected done=0 in_ready=1", done, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
        pixel_in = '0; weight_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rs0, rs1, rs2, done, in_ready} !== {24'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: sums=%0d,%0d,%0d done=%0b rdy=%0b expected 0,0,0 0 0",
                     rs0, rs1, rs2, done, in_ready);
        end
        rst_n = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_ones();
        logic [DW-1:0] px[9], wt[9];
        for (int i = 0; i < 9; i++) begin px[i] = 8'd1; wt[i] = 8'd1; end
        push_expected(px, wt);
        send_pairs(px, wt, 9, 1'b0);
        checks++;
        if ({done, rs0, rs1, rs2} !== {1'b1, 8'd3, 8'd3, 8'd3}) begin
            failures++;
            $display("FAIL ones_latency: done=%0b sums=%0d,%0d,%0d expected 1 3,3,3",
                     done, rs0, rs1, rs2);
        end
        do_ack();
    endtask

    task automatic test_hold_stable();
        logic [DW-1:0] px[9], wt[9];
        for (int i = 0; i < 9; i++) begin px[i] = DW'(i + 1); wt[i] = 8'd1; end
        push_expected(px, wt);
        send_pairs(px, wt, 9, 1'b0);
        in_valid = 1'b1; pixel_in = 8'd99; weight_in = 8'd99;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({done, in_ready, rs0, rs1, rs2} !== {1'b1, 1'b0, 8'd6, 8'd15, 8'd24}) begin
                failures++;
                $display("FAIL hold_stable cyc%0d: done=%0b rdy=%0b sums=%0d,%0d,%0d expected 1 0 6,15,24",
                         c, done, in_ready, rs0, rs1, rs2);
            end
        end
        in_valid = 1'b0;
        do_ack();
    endtask

    task automatic test_saturate();
        logic [DW-1:0] px[9], wt[9];
        for (int i = 0; i < 9; i++) begin px[i] = 8'd200; wt[i] = 8'd2; end
        push_expected(px, wt);
        send_pairs(px, wt, 9, 1'b0);
        checks++;
        if ({rs0, rs1, rs2, ss0, ss1, ss2} !== {8'd176, 8'd176, 8'd176, 8'd255, 8'd255, 8'd255}) begin
            failures++;
            $display("FAIL saturate: mod=%0d,%0d,%0d sat=%0d,%0d,%0d expected 176x3 255x3",
                     rs0, rs1, rs2, ss0, ss1, ss2);
        end
        do_ack();
    endtask

    task automatic test_gaps();
        logic [DW-1:0] px[9], wt[9];
        for (int i = 0; i < 9; i++) begin px[i] = DW'(i + 1); wt[i] = 8'd2; end
        push_expected(px, wt);
        send_pairs(px, wt, 9, 1'b1);
        checks++;
        if ({done, rs0, rs1, rs2} !== {1'b1, 8'd12, 8'd30, 8'd48}) begin
            failures++;
            $display("FAIL gaps: done=%0b sums=%0d,%0d,%0d expected 1 12,30,48",
                     done, rs0, rs1, rs2);
        end
        do_ack();
    endtask

    task automatic test_enable_abort();
        logic [DW-1:0] px[9], wt[9];
        for (int i = 0; i < 9; i++) begin px[i] = DW'(i + 1); wt[i] = 8'd1; end
        send_pairs(px, wt, 5, 1'b0);
        checks++;
        if (rs0 !== 8'd6) begin
            failures++;
            $display("FAIL partial_row0: row_sum0=%0d expected 6", rs0);
        end
        enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rs0, rs1, rs2, done, in_ready} !== {24'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL enable_abort: sums=%0d,%0d,%0d done=%0b rdy=%0b expected 0,0,0 0 0",
                     rs0, rs1, rs2, done, in_ready);
        end
        enable = 1'b1;
        push_expected(px, wt);
        send_pairs(px, wt, 9, 1'b0);
        checks++;
        if ({done, rs0, rs1, rs2} !== {1'b1, 8'd6, 8'd15, 8'd24}) begin
            failures++;
            $display("FAIL after_abort: done=%0b sums=%0d,%0d,%0d expected 1 6,15,24",
                     done, rs0, rs1, rs2);
        end
        do_ack();
    endtask

    task automatic test_rst_midwindow();
        logic [DW-1:0] px[9], wt[9], tw[9];
        for (int i = 0; i < 9; i++) begin px[i] = DW'(i + 1); wt[i] = 8'd1; tw[i] = 8'd2; end
        send_pairs(px, wt, 4, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({rs0, rs1, rs2, done, in_ready} !== {24'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_rst: sums=%0d,%0d,%0d done=%0b rdy=%0b expected 0,0,0 0 0",
                     rs0, rs1, rs2, done, in_ready);
        end
        rst_n = 1'b1;
        push_expected(px, wt);
        send_pairs(px, wt, 9, 1'b0);
        checks++;
        if ({done, rs0, rs1, rs2} !== {1'b1, 8'd6, 8'd15, 8'd24}) begin
            failures++;
            $display("FAIL after_rst: done=%0b sums=%0d,%0d,%0d expected 1 6,15,24",
                     done, rs0, rs1, rs2);
        end
        do_ack();
        push_expected(tw, wt);
        send_pairs(tw, wt, 9, 1'b0);
        checks++;
        if ({done, rs0, rs1, rs2} !== {1'b1, 8'd6, 8'd6, 8'd6}) begin
            failures++;
            $display("FAIL second_window: done=%0b sums=%0d,%0d,%0d expected 1 6,6,6",
                     done, rs0, rs1, rs2);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_ones();
        test_hold_stable();
        test_saturate();
        test_gaps();
        test_enable_abort();
        test_rst_midwindow();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d windows never completed, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
